eth_tx_framer: RTL
==================

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 60, minimum bytes from destination address to end of pad, FCS excluded.
REQ-002 SHALL have parameter IFG_CYCLES, default 24, idle clocks enforced after each frame (12 byte times at nibble rate).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_data  input  8  payload byte, destination address first.
REQ-006 SHALL have port s_valid  input  1  s_data valid.
REQ-007 SHALL have port s_last  input  1  marks final payload byte.
REQ-008 SHALL have port s_ready  output  1  payload byte accepted when s_valid && s_ready.
REQ-009 SHALL have port tx_data  output  8  byte to MII transmitter.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port tx_ready  input  1  transmitter takes tx_data when tx_valid && tx_ready.
REQ-012 SHALL have port tx_start  output  1  one-cycle start-of-frame pulse.
REQ-013 SHALL have ports frame_done and underrun  output  1 each  one-cycle status pulses.

Function
REQ-014 SHALL implement states IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG.
REQ-015 IDLE -> PREAMBLE when s_valid=1; tx_start=1 for exactly that cycle; s_ready=0 in IDLE.
REQ-016 PREAMBLE: tx_data=0x55, tx_valid=1, 7 transfers, then SFD: tx_data=0xD5, 1 transfer.
REQ-017 PAYLOAD: tx_data=s_data, tx_valid=s_valid, s_ready=tx_ready (pass-through, zero latency).
REQ-018 An 11-bit byte counter SHALL count transfers from PAYLOAD onward, saturating at 2047; oversize frames not truncated.
REQ-019 On accepted s_last: count<MIN_FRAME -> PAD, else FCS (or IFG without FCS_EN).
REQ-020 PAD: tx_data=0x00, tx_valid=1 until count reaches MIN_FRAME.
REQ-021 CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) SHALL update on every PAYLOAD/PAD transfer; preamble/SFD excluded.
REQ-022 FCS: 4 transfers of ~crc, least-significant byte first.
REQ-023 Underrun: s_valid=0 in PAYLOAD after first payload byte and before s_last SHALL pulse underrun, force tx_valid=0, skip PAD/FCS, go to IFG; upstream SHALL drop the remainder.
REQ-024 IFG: tx_valid=0, s_ready=0 for IFG_CYCLES clocks, then IDLE; frame_done pulses on IFG entry from normal completion only.
REQ-025 tx_valid SHALL stay high and tx_data stable while tx_ready=0 in PREAMBLE/SFD/PAD/FCS.
REQ-026 s_last with a single-byte payload SHALL be legal (59 pad bytes follow).

Reset
REQ-027 reset=1 SHALL in the next cycle force IDLE, counters/IFG timer 0, CRC 0xFFFFFFFF, tx_valid=0, tx_start=0, s_ready=0, tx_data=0x00, frame_done=0, underrun=0, including mid-frame.

Configuration
REQ-028 Macro ETH_TX_FRAMER_FCS_EN defined: CRC logic and FCS state present per REQ-021/022.
REQ-029 Macro undefined: no CRC logic; PAD/PAYLOAD completion goes directly to IFG; frame is 4 bytes shorter.

Structure
REQ-030 Package eth_pkg SHALL hold PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_POLY 0xEDB88320, CRC_INIT 0xFFFFFFFF, and the state enum.
REQ-031 Byte-wise CRC update SHALL be sub-module crc32_d8 (crc_in, data -> crc_out, combinational), instantiated only under ETH_TX_FRAMER_FCS_EN.

Verification
REQ-032 64-byte payload 0x00..0x3F, tx_ready=1 -> tx_start once, 7x0x55, 0xD5, 64 payload bytes, 4 FCS bytes matching model, frame_done once.
REQ-033 1-byte payload 0xAB -> 0xAB then 59x0x00 then FCS over 60 bytes; total 72 transfers.
REQ-034 crc32_d8 chained over ASCII "123456789" from 0xFFFFFFFF -> complemented result 0xCBF43926 (FCS bytes 26 39 F4 CB).
REQ-035 tx_ready toggling 1-of-3 cycles -> byte sequence identical to REQ-032, no byte duplicated or lost.
REQ-036 s_valid dropped after 10 payload bytes -> underrun pulse, tx_valid=0, no FCS, next tx_start no earlier than 24 clocks later.
REQ-037 reset asserted during FCS -> next cycle tx_valid=0, state IDLE; following frame completes with correct FCS.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg
//   Shared constants and types for the Ethernet transmit framer.
//   Holds the preamble/SFD byte values, the reflected CRC-32 polynomial
//   and seed, the fixed preamble and FCS lengths, and the framer state enum.
//   No ports (package only).
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  // Seven preamble transfers precede the single SFD transfer.
  localparam int PREAMBLE_LEN = 7;
  // The frame check sequence is four bytes.
  localparam int FCS_LEN      = 4;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    PAD,
    FCS,
    IFG
  } tx_state_e;

endpackage

// File: rtl/eth_tx_framer_crc32_d8.sv
// crc32_d8
//   Combinational byte-wide update of the Ethernet CRC-32 (reflected form,
//   polynomial 0xEDB88320). Bytes are consumed least-significant bit first,
//   matching the on-wire bit order of Ethernet.
//   Ports:
//     crc_in  [31:0] in   running CRC before this byte
//     data    [7:0]  in   byte to fold into the CRC
//     crc_out [31:0] out  running CRC after this byte (not complemented)
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Fold the byte into the low bits, then run eight shift/conditional-XOR
  // steps; the loop unrolls into a flat XOR network.
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// eth_tx_framer
//   Wraps a byte stream (destination address first) into an Ethernet frame:
//   7x preamble, SFD, payload passed straight through, zero padding up to
//   MIN_FRAME bytes, optional 4-byte FCS, then an enforced inter-frame gap.
//   A gap in s_valid mid-payload aborts the frame (underrun) and jumps to
//   the inter-frame gap without padding or FCS.
//
//   Build option: define ETH_TX_FRAMER_FCS_EN to include the CRC-32 engine
//   and FCS state. Without it, frames end after payload/pad (4 bytes shorter).
//
//   Parameters:
//     MIN_FRAME   minimum bytes from destination address to end of pad
//     IFG_CYCLES  idle clocks enforced after every frame
//   Ports:
//     clk         in   single clock
//     reset       in   synchronous active-high reset
//     s_data[7:0] in   payload byte
//     s_valid     in   s_data valid
//     s_last      in   final payload byte
//     s_ready     out  payload byte accepted when s_valid && s_ready
//     tx_data[7:0] out byte to the MII transmitter
//     tx_valid    out  tx_data valid
//     tx_ready    in   transmitter takes tx_data when tx_valid && tx_ready
//     tx_start    out  one-cycle pulse in the first preamble cycle
//     frame_done  out  one-cycle pulse on entering the gap after a good frame
//     underrun    out  one-cycle pulse on entering the gap after an underrun
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME  = 60,
  parameter int IFG_CYCLES = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [10:0] BYTE_CNT_MAX  = 11'h7FF;
  localparam logic [11:0] MIN_FRAME_W   = 12'(MIN_FRAME);
  localparam logic [15:0] IFG_LAST      = 16'(IFG_CYCLES - 1);
  localparam logic [2:0]  PREAMBLE_LAST = 3'(PREAMBLE_LEN - 1);

`ifdef ETH_TX_FRAMER_FCS_EN
  localparam logic [2:0]  FCS_LAST      = 3'(FCS_LEN - 1);
  // Good frames continue into the FCS; frame_done is raised after it.
  localparam tx_state_e   DONE_STATE    = FCS;
  localparam logic        DONE_PULSE    = 1'b0;
`else
  // Without an FCS, good frames go straight into the gap.
  localparam tx_state_e   DONE_STATE    = IFG;
  localparam logic        DONE_PULSE    = 1'b1;
`endif

  tx_state_e   state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] ifg_q, ifg_d;
  logic        tx_start_q, tx_start_d;
  logic        frame_done_q, frame_done_d;
  logic        underrun_q, underrun_d;

  logic        xfer;
  logic [10:0] byte_cnt_inc;
  logic [11:0] count_after;
  logic        at_min;

  assign xfer         = tx_valid && tx_ready;
  // Counter sticks at its maximum so oversize frames keep flowing untouched.
  assign byte_cnt_inc = (byte_cnt_q == BYTE_CNT_MAX) ? byte_cnt_q : byte_cnt_q + 11'd1;
  // Count including the byte transferring this cycle; 12 bits so 2047+1 cannot wrap.
  assign count_after  = {1'b0, byte_cnt_q} + 12'd1;
  assign at_min       = (count_after >= MIN_FRAME_W);

  assign tx_start   = tx_start_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  // State register plus the beat, byte and gap counters and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      byte_cnt_q   <= '0;
      ifg_q        <= '0;
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      byte_cnt_q   <= byte_cnt_d;
      ifg_q        <= ifg_d;
      tx_start_q   <= tx_start_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  // Next-state logic. Status pulses are registered so each appears in the
  // first cycle of the state it announces.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    byte_cnt_d   = byte_cnt_q;
    ifg_d        = ifg_q;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        beat_d     = '0;
        byte_cnt_d = '0;
        ifg_d      = '0;
        if (s_valid) begin
          state_d    = PREAMBLE;
          tx_start_d = 1'b1;
        end
      end

      PREAMBLE: begin
        if (xfer) begin
          if (beat_q == PREAMBLE_LAST) begin
            state_d = SFD;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end

      SFD: begin
        if (xfer) begin
          state_d = PAYLOAD;
        end
      end

      PAYLOAD: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_inc;
          if (s_last) begin
            if (!at_min) begin
              state_d = PAD;
            end else begin
              state_d      = DONE_STATE;
              frame_done_d = DONE_PULSE;
              beat_d       = '0;
              ifg_d        = '0;
            end
          end
        end else if (!s_valid && (byte_cnt_q != 11'd0)) begin
          // Source ran dry mid-frame: abandon it, no pad and no FCS.
          state_d    = IFG;
          underrun_d = 1'b1;
          ifg_d      = '0;
        end
      end

      PAD: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_inc;
          if (at_min) begin
            state_d      = DONE_STATE;
            frame_done_d = DONE_PULSE;
            beat_d       = '0;
            ifg_d        = '0;
          end
        end
      end

`ifdef ETH_TX_FRAMER_FCS_EN
      FCS: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_inc;
          if (beat_q == FCS_LAST) begin
            state_d      = IFG;
            frame_done_d = 1'b1;
            ifg_d        = '0;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
`endif

      IFG: begin
        if (ifg_q >= IFG_LAST) begin
          state_d = IDLE;
        end else begin
          ifg_d = ifg_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ETH_TX_FRAMER_FCS_EN
  logic [31:0] crc_q, crc_d, crc_next, fcs_word;

  crc32_d8 u_crc32_d8 (
    .crc_in  (crc_q),
    .data    (tx_data),
    .crc_out (crc_next)
  );

  assign fcs_word = ~crc_q;

  // CRC is reseeded while idle and folds in every payload/pad byte that the
  // transmitter actually takes; it holds steady while the FCS is sent.
  always_comb begin
    crc_d = crc_q;
    if (state_q == IDLE) begin
      crc_d = CRC_INIT;
    end else if ((state_q == PAYLOAD || state_q == PAD) && xfer) begin
      crc_d = crc_next;
    end
  end

  // CRC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end
`endif

  // Output decode. Payload is a zero-latency pass-through, so both s_ready and
  // tx_valid follow the opposite side's handshake directly in that state.
  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    s_ready  = 1'b0;

    case (state_q)
      PREAMBLE: begin
        tx_data  = PREAMBLE_BYTE;
        tx_valid = 1'b1;
      end
      SFD: begin
        tx_data  = SFD_BYTE;
        tx_valid = 1'b1;
      end
      PAYLOAD: begin
        tx_data  = s_data;
        tx_valid = s_valid;
        s_ready  = tx_ready;
      end
      PAD: begin
        tx_data  = 8'h00;
        tx_valid = 1'b1;
      end
`ifdef ETH_TX_FRAMER_FCS_EN
      FCS: begin
        tx_valid = 1'b1;
        case (beat_q[1:0])
          2'd0:    tx_data = fcs_word[7:0];
          2'd1:    tx_data = fcs_word[15:8];
          2'd2:    tx_data = fcs_word[23:16];
          default: tx_data = fcs_word[31:24];
        endcase
      end
`endif
      default: begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
      end
    endcase
  end

endmodule
